// File: rtl/pwm_cmd_pkg.sv
// Shared types and constants for the PWM command-frame parser.
// Frame format depends on PWM_CMD_CHECKSUM_EN (see pwm_cmd_parser).
package pwm_cmd_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'h53;
    localparam logic [7:0] ACK_BYTE         = 8'h06;
    localparam logic [7:0] NAK_BYTE         = 8'h15;
    localparam logic [7:0] DUTY_MAX         = 8'd100;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_GET_FREQ = 3'd1;
    localparam state_t ST_GET_DUTY = 3'd2;
    localparam state_t ST_GET_CSUM = 3'd3;
    localparam state_t ST_APPLY    = 3'd4;
    localparam state_t ST_RESP     = 3'd5;

endpackage

// File: rtl/pwm_cmd_timer.sv
// Saturating inter-byte idle counter; expired flags the cycle the limit is reached.
module pwm_cmd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + W'(1);
        end
    end

    assign expired = en && (count == LIMIT);

endmodule

// File: rtl/pwm_cmd_parser.sv
// UART command-frame parser driving PWM configuration with ACK/NAK response.
// Define PWM_CMD_CHECKSUM_EN for 4-byte frames with an XOR checksum byte.
module pwm_cmd_parser
    import pwm_cmd_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] pow2_cfg,
    output logic [1:0] pow5_cfg,
    output logic [6:0] duty_cfg,
    output logic       cfg_valid,
    output logic       busy
);

    state_t     state;
    logic [7:0] freq_b;
    logic [7:0] duty_b;
`ifdef PWM_CMD_CHECKSUM_EN
    logic [7:0] csum_b;
`endif
    logic [1:0] pow2_q;
    logic [1:0] pow5_q;
    logic [6:0] duty_q;

    logic in_frame;
    logic timer_clr;
    logic expired;
    logic frame_good;
    logic apply_good;

    assign in_frame  = (state == ST_GET_FREQ) || (state == ST_GET_DUTY)
`ifdef PWM_CMD_CHECKSUM_EN
                    || (state == ST_GET_CSUM)
`endif
                    ;
    assign timer_clr = rx_valid && (in_frame || ((state == ST_IDLE) && (rx_data == HDR_BYTE)));

    pwm_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (in_frame),
        .expired (expired)
    );

    always_comb begin
        frame_good = (freq_b[7:4] == 4'd0) && (duty_b < DUTY_MAX);
`ifdef PWM_CMD_CHECKSUM_EN
        frame_good = frame_good && (csum_b == (freq_b ^ duty_b));
`endif
    end

    // New config is presented combinationally during APPLY so it appears
    // together with cfg_valid one cycle after the last frame byte.
    assign apply_good = (state == ST_APPLY) && frame_good;
    assign cfg_valid  = apply_good;
    assign pow2_cfg   = apply_good ? freq_b[1:0] : pow2_q;
    assign pow5_cfg   = apply_good ? freq_b[3:2] : pow5_q;
    assign duty_cfg   = apply_good ? duty_b[6:0] : duty_q;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            freq_b   <= '0;
            duty_b   <= '0;
`ifdef PWM_CMD_CHECKSUM_EN
            csum_b   <= '0;
`endif
            pow2_q   <= '0;
            pow5_q   <= '0;
            duty_q   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == HDR_BYTE)) begin
                        state <= ST_GET_FREQ;
                    end
                end
                ST_GET_FREQ: begin
                    if (rx_valid) begin
                        freq_b <= rx_data;
                        state  <= ST_GET_DUTY;
                    end else if (expired) begin
                        tx_data  <= NAK_BYTE;
                        tx_valid <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
                ST_GET_DUTY: begin
                    if (rx_valid) begin
                        duty_b <= rx_data;
`ifdef PWM_CMD_CHECKSUM_EN
                        state  <= ST_GET_CSUM;
`else
                        state  <= ST_APPLY;
`endif
                    end else if (expired) begin
                        tx_data  <= NAK_BYTE;
                        tx_valid <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
`ifdef PWM_CMD_CHECKSUM_EN
                ST_GET_CSUM: begin
                    if (rx_valid) begin
                        csum_b <= rx_data;
                        state  <= ST_APPLY;
                    end else if (expired) begin
                        tx_data  <= NAK_BYTE;
                        tx_valid <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
`endif
                ST_APPLY: begin
                    if (frame_good) begin
                        pow2_q  <= freq_b[1:0];
                        pow5_q  <= freq_b[3:2];
                        duty_q  <= duty_b[6:0];
                        tx_data <= ACK_BYTE;
                    end else begin
                        tx_data <= NAK_BYTE;
                    end
                    tx_valid <= 1'b1;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cmd_parser.sv
// Scoreboard bench for pwm_cmd_parser; adapts frame length to PWM_CMD_CHECKSUM_EN.
module tb_pwm_cmd_parser;

`ifdef PWM_CMD_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [1:0] pow2_cfg;
    logic [1:0] pow5_cfg;
    logic [6:0] duty_cfg;
    logic       cfg_valid;
    logic       busy;

    pwm_cmd_parser #(
        .HDR_BYTE       (8'h53),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .pow2_cfg  (pow2_cfg),
        .pow5_cfg  (pow5_cfg),
        .duty_cfg  (duty_cfg),
        .cfg_valid (cfg_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] p2;
        logic [1:0] p5;
        logic [6:0] d;
    } cfg_t;

    int   total = 0;
    int   bad = 0;
    logic [7:0] exp_tx[$];
    cfg_t exp_cfg[$];
    cfg_t cur_cfg = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents cfg_valid or a tx handshake.
    logic       prev_cfg_valid = 1'b0;
    logic       prev_tx_wait = 1'b0;
    logic [7:0] prev_tx = '0;

    always @(negedge clk) begin
        cfg_t e;
        logic [7:0] b;
        if (rst) begin
            prev_cfg_valid = 1'b0;
            prev_tx_wait   = 1'b0;
            cur_cfg        = '0;
        end else begin
            if (cfg_valid) begin
                check("cfg_pulse_width", 32'(prev_cfg_valid), 32'd0);
                if (exp_cfg.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cfg_unexpected: got cfg %0h want none", {pow2_cfg, pow5_cfg, duty_cfg});
                end else begin
                    e = exp_cfg.pop_front();
                    check("cfg_value", 32'({pow2_cfg, pow5_cfg, duty_cfg}), 32'(e));
                    cur_cfg = e;
                end
            end
            if (tx_valid && prev_tx_wait)
                check("tx_hold", 32'(tx_data), 32'(prev_tx));
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected: got %0h want none", tx_data);
                end else begin
                    b = exp_tx.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(b));
                    check("cfg_hold", 32'({pow2_cfg, pow5_cfg, duty_cfg}), 32'(cur_cfg));
                end
            end
            prev_cfg_valid = cfg_valid;
            prev_tx_wait   = tx_valid && !tx_ready;
            prev_tx        = tx_data;
        end
    end

    // Stimulus tasks start and end #1 after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_exp(input logic [7:0] f, input logic [7:0] d, input bit good);
        cfg_t e;
        if (good) begin
            e.p2 = f[1:0];
            e.p5 = f[3:2];
            e.d  = d[6:0];
            exp_cfg.push_back(e);
            exp_tx.push_back(8'h06);
        end else begin
            exp_tx.push_back(8'h15);
        end
    endtask

    task automatic send_frame(input logic [7:0] f, input logic [7:0] d, input logic [7:0] c, input bit good);
        push_exp(f, d, good);
        send_byte(8'h53);
        send_byte(f);
        send_byte(d);
        if (CSUM) send_byte(c);
        @(negedge clk);
        check("cfg_valid_latency", 32'(cfg_valid), 32'(good));
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_tx.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_tx.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, exp_tx.size());
            exp_tx.delete();
            exp_cfg.delete();
        end
        @(negedge clk);
        check({name, "_idle"}, 32'({tx_valid, busy}), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({pow2_cfg, pow5_cfg, duty_cfg, cfg_valid, tx_valid, tx_data, busy}), 32'd0);
    endtask

    initial begin
        idle(3);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        send_frame(8'h09, 8'h32, 8'h3B, 1'b1);
        wait_done("good_frame");

        send_frame(8'h00, 8'h64, 8'h64, 1'b0);
        wait_done("duty_100");

        send_frame(8'h20, 8'h10, 8'h30, 1'b0);
        wait_done("freq_nibble");

        send_frame(8'h05, 8'h0A, 8'h00, !CSUM);
        wait_done("bad_csum");

        // Timeout after the FREQ byte.
        push_exp(8'h05, 8'h00, 1'b0);
        send_byte(8'h53);
        send_byte(8'h05);
        check("busy_in_frame", 32'(busy), 32'd1);
        wait_done("timeout");

        // Byte arriving exactly on the expiry cycle is accepted.
        push_exp(8'h05, 8'h0A, 1'b1);
        send_byte(8'h53);
        send_byte(8'h05);
        idle(16);
        send_byte(8'h0A);
        if (CSUM) send_byte(8'h0F);
        wait_done("byte_wins");

        // Back-pressure in RESP with extra rx bytes that must be ignored.
        tx_ready = 1'b0;
        send_frame(8'h03, 8'h63, 8'h60, 1'b1);
        idle(5);
        send_byte(8'h53);
        send_byte(8'h09);
        idle(13);
        check("busy_in_resp", 32'({busy, tx_valid}), 32'd3);
        tx_ready = 1'b1;
        wait_done("backpressure");

        // Reset mid-frame, then a fresh frame.
        send_byte(8'h53);
        send_byte(8'h09);
        if (CSUM) send_byte(8'h32);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid_frame");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);
        check("idle_after_reset", 32'({busy, tx_valid, cfg_valid}), 32'd0);
        send_frame(8'h0E, 8'h4A, 8'h44, 1'b1);
        wait_done("after_reset");

        check("queues_empty", 32'(exp_tx.size() + exp_cfg.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
